nibble_serial_sub_ctrl: RTL and testbench
=========================================

Name: nibble_serial_sub_ctrl

Overview:
Sequencer that performs a wide subtraction (a - b - bin) with one shared 4-bit ripple-borrow subtractor stage. It processes one nibble per clock, LSB nibble first, and registers the borrow between nibbles. It sits in front of the 4-bit structural subtractor datapath so wide operands reuse a single nibble slice. A start/busy/done handshake lets a host launch one operation at a time.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width is W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  W  minuend; captured on the accepted start
b  input  W  subtrahend; captured on the accepted start
bin  input  1  borrow-in; captured on the accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
diff  output  W  difference a - b - bin mod 2^W
bout  output  1  final borrow-out; 1 when a < b + bin
zero  output  1  1 when diff == 0; valid with done and after it

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (rst=1 at a clock edge): state goes to IDLE; busy, done, diff, bout and zero all become 0; the nibble index and borrow register clear. Reset has priority over every other input.
- IDLE:
  - On an edge with start=1: latch a, b and bin into operand and borrow registers; clear diff, bout and zero; set the index to 0; go to RUN.
  - With start=0: hold all outputs.
- RUN: each edge processes nibble i = index.
  - Compute {borrow, d} = a[4i+3:4i] - b[4i+3:4i] - borrow_reg. Per bit this is full-subtractor logic: d = x^y^c; borrow = (~x&y) | (~(x^y)&c).
  - Write d into diff[4i+3:4i] and update borrow_reg. Increment the index.
  - On the edge that processes i = NIBBLES-1: set bout = borrow, set zero = (final diff == 0), go to DONE.
- DONE: done=1 for exactly this one cycle, then go unconditionally to IDLE.
- Output hold: diff, bout and zero hold their values from DONE until the next accepted start or reset.
- Latency: start accepted at edge k; RUN edges are k+1 .. k+NIBBLES; done is high in the cycle after edge k+NIBBLES. The first result appears NIBBLES+1 cycles after the start edge. The next start can be accepted at edge k+NIBBLES+2 at the earliest.
- busy=1 only in RUN; done=1 only in DONE; busy and done are never high together.
- start while in RUN or DONE is ignored and not queued. a, b and bin may change freely after the start edge without affecting the result.
- During RUN, diff shows partial results; these are not valid until done.
- Reset mid-RUN aborts the operation: no done pulse, and all outputs read 0 on the next cycle.
- NIBBLES=1: RUN lasts one cycle and the result equals a single 4-bit subtractor.
- Wrap-around: a result below zero wraps modulo 2^W with bout=1. Borrow propagates across every nibble boundary, including runs of 0xF.

Test Plan:
1. NIBBLES=4; a=16'h1234, b=16'h0235, bin=0, pulse start -> busy high 4 cycles; done in cycle 5 after start; diff=16'h0FFF, bout=0, zero=0.
2. NIBBLES=4; a=16'h0000, b=16'h0001, bin=0 -> full borrow ripple across all nibbles; diff=16'hFFFF, bout=1, zero=0.
3. NIBBLES=4; a=b=16'hBEEF: with bin=0 -> diff=16'h0000, zero=1, bout=0; rerun with bin=1 -> diff=16'hFFFF, bout=1, zero=0.
4. NIBBLES=1; a=4'b1011, b=4'b1111, bin=0 -> done 2 cycles after start; diff=4'b1100, bout=1.
5. NIBBLES=4; start held high continuously with operands changed mid-RUN -> exactly one done per accepted start, spaced 6 cycles apart; each result matches the operands captured at its own start edge.
6. NIBBLES=4; assert rst for one edge after 2 RUN cycles -> next cycle busy=0, done=0, diff=0, bout=0, zero=0; no done pulse appears; a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/nibble_serial_sub_ctrl_if.sv
// rtl/nibble_serial_sub_ctrl_if.sv - host/sequencer handshake bundle for the nibble-serial subtractor
interface nibble_serial_sub_ctrl_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, zero
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, zero
   );
endinterface

// File: rtl/nibble_serial_sub_ctrl.sv
// rtl/nibble_serial_sub_ctrl.sv - wide a-b-bin computed one nibble per clock through a shared 4-bit slice
module nibble_serial_sub_ctrl #(
   parameter int NIBBLES = 4
) (
   input logic                     clk,
   input logic                     rst,
   nibble_serial_sub_ctrl_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            brw_q;
   logic [IW-1:0]   idx_q;
   logic [W-1:0]    diff_q;
   logic            bout_q;
   logic            zero_q;

   logic [3:0]      x;
   logic [3:0]      y;
   logic [3:0]      d_nib;
   logic [4:0]      c;
   logic [W-1:0]    diff_n;
   logic            last;

   assign last = (idx_q == IW'(NIBBLES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: a start is only honoured in IDLE, DONE always lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Shared nibble slice: ripple-borrow full subtractor over the current nibble
   always_comb begin
      x      = a_q[{idx_q, 2'b00} +: 4];
      y      = b_q[{idx_q, 2'b00} +: 4];
      c      = '0;
      d_nib  = '0;
      c[0]   = brw_q;
      for (int i = 0; i < 4; i++) begin
         d_nib[i] = x[i] ^ y[i] ^ c[i];
         c[i+1]   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c[i]);
      end
      diff_n = diff_q;
      diff_n[{idx_q, 2'b00} +: 4] = d_nib;
   end

   // Operand capture, per-nibble result write-back and final flags
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         brw_q  <= 1'b0;
         idx_q  <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  brw_q  <= bus.bin;
                  idx_q  <= '0;
                  diff_q <= '0;
                  bout_q <= 1'b0;
                  zero_q <= 1'b0;
               end
            end
            S_RUN: begin
               diff_q <= diff_n;
               brw_q  <= c[4];
               idx_q  <= idx_q + IW'(1);
               if (last) begin
                  bout_q <= c[4];
                  zero_q <= (diff_n == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state_q == S_RUN);
   assign bus.done = (state_q == S_DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.zero = zero_q;
endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// tb/tb_nibble_serial_sub_ctrl.sv - self-checking bench for nibble_serial_sub_ctrl (4- and 1-nibble builds)
module tb_nibble_serial_sub_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   nibble_serial_sub_ctrl_if #(.NIBBLES(4)) i4 ();
   nibble_serial_sub_ctrl_if #(.NIBBLES(1)) i1 ();

   nibble_serial_sub_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(i4.slave));
   nibble_serial_sub_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: integer subtraction, wrapped into w bits; borrow means the true result went negative
   task automatic ref_sub(input int w, input longint a, input longint b, input int bin,
                          output longint d, output bit bo);
      longint r;
      r  = a - b - longint'(bin);
      bo = (r < 0);
      if (r < 0) r = r + (longint'(1) << w);
      d  = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic bin, input string tag);
      longint ed;
      bit     eb;
      ref_sub(16, longint'(a), longint'(b), int'(bin), ed, eb);
      i4.a = a; i4.b = b; i4.bin = bin; i4.start = 1'b1;
      tick();
      i4.start = 1'b0;
      i4.a = 16'($urandom); i4.b = 16'($urandom); i4.bin = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
         chk({tag, ".busy"}, 32'(i4.busy), 32'd1);
         chk({tag, ".nodone"}, 32'(i4.done), 32'd0);
         tick();
      end
      chk({tag, ".done"}, 32'(i4.done), 32'd1);
      chk({tag, ".busy_lo"}, 32'(i4.busy), 32'd0);
      chk({tag, ".diff"}, 32'(i4.diff), 32'(ed));
      chk({tag, ".bout"}, 32'(i4.bout), 32'(eb));
      chk({tag, ".zero"}, 32'(i4.zero), 32'(ed == 0));
      tick();
      chk({tag, ".done_lo"}, 32'(i4.done), 32'd0);
      chk({tag, ".hold"}, {15'd0, i4.zero, i4.bout, i4.diff}, {15'd0, 1'(ed == 0), eb, 16'(ed)});
   endtask

   task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic bin, input string tag);
      longint ed;
      bit     eb;
      ref_sub(4, longint'(a), longint'(b), int'(bin), ed, eb);
      i1.a = a; i1.b = b; i1.bin = bin; i1.start = 1'b1;
      tick();
      i1.start = 1'b0;
      i1.a = 4'($urandom); i1.b = 4'($urandom);
      chk({tag, ".busy"}, 32'(i1.busy), 32'd1);
      chk({tag, ".nodone"}, 32'(i1.done), 32'd0);
      tick();
      chk({tag, ".done"}, 32'(i1.done), 32'd1);
      chk({tag, ".diff"}, 32'(i1.diff), 32'(ed));
      chk({tag, ".bout"}, 32'(i1.bout), 32'(eb));
      chk({tag, ".zero"}, 32'(i1.zero), 32'(ed == 0));
      tick();
      chk({tag, ".done_lo"}, 32'(i1.done), 32'd0);
   endtask

   logic [15:0] qa [0:17];
   logic [15:0] qb [0:17];
   logic        qc [0:17];
   int          n_done;
   longint      ed;
   bit          eb;

   initial begin
      i4.start = 1'b0; i4.a = '0; i4.b = '0; i4.bin = 1'b0;
      i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.bin = 1'b0;
      rst = 1'b1;
      tick();
      i4.start = 1'b1;
      tick();
      chk("reset4", {27'd0, i4.busy, i4.done, i4.bout, i4.zero, |i4.diff}, 32'd0);
      chk("reset1", {27'd0, i1.busy, i1.done, i1.bout, i1.zero, |i1.diff}, 32'd0);
      i4.start = 1'b0;
      rst = 1'b0;
      tick();

      op4(16'h1234, 16'h0235, 1'b0, "t1");
      op4(16'h0000, 16'h0001, 1'b0, "t2_ripple");
      op4(16'hBEEF, 16'hBEEF, 1'b0, "t3_eq");
      op4(16'hBEEF, 16'hBEEF, 1'b1, "t3_eq_bin");
      op4(16'hF000, 16'h0FFF, 1'b1, "t_ffrun");
      op4(16'hFFFF, 16'h0000, 1'b0, "t_max");
      for (int r = 0; r < 8; r++)
         op4(16'($urandom), 16'($urandom), 1'($urandom), "t_rand4");

      op1(4'b1011, 4'b1111, 1'b0, "t4");
      op1(4'h0, 4'h0, 1'b1, "t4_bin");
      for (int r = 0; r < 6; r++)
         op1(4'($urandom), 4'($urandom), 1'($urandom), "t_rand1");

      // start held high with operands changing every cycle: accepts at offsets 0, 6, 12
      n_done = 0;
      for (int t = 0; t < 18; t++) begin
         qa[t] = 16'($urandom); qb[t] = 16'($urandom); qc[t] = 1'($urandom);
         i4.a = qa[t]; i4.b = qb[t]; i4.bin = qc[t]; i4.start = 1'b1;
         tick();
         if (i4.done) n_done++;
         if (t % 6 == 4) begin
            ref_sub(16, longint'(qa[t-4]), longint'(qb[t-4]), int'(qc[t-4]), ed, eb);
            chk("t5.done", 32'(i4.done), 32'd1);
            chk("t5.diff", 32'(i4.diff), 32'(ed));
            chk("t5.bout", 32'(i4.bout), 32'(eb));
         end else begin
            chk("t5.nodone", 32'(i4.done), 32'd0);
         end
      end
      chk("t5.count", 32'(n_done), 32'd3);
      i4.start = 1'b0;
      tick();
      tick();

      // reset after two RUN edges aborts the operation
      i4.a = 16'h8000; i4.b = 16'h0001; i4.bin = 1'b0; i4.start = 1'b1;
      tick();
      i4.start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6.clear", {27'd0, i4.busy, i4.done, i4.bout, i4.zero, |i4.diff}, 32'd0);
      n_done = 0;
      for (int k = 0; k < 8; k++) begin
         if (i4.done || i4.busy) n_done++;
         tick();
      end
      chk("t6.no_done", 32'(n_done), 32'd0);
      op4(16'h8000, 16'h0001, 1'b0, "t6_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
